// File: rtl/usb_tx_pkg.sv
// Shared types and helpers for the multi-endpoint USB TX buffer.
//   wr_size_t      : encoding of the AHB write size
//   size_to_bytes(): byte count of a write size (0 for the reserved code)
//   size_to_be()   : byte-lane enables of a write size (lane 0 = tx_data[7:0])
package usb_tx_pkg;

  localparam int MAX_EP = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } wr_size_t;

  function automatic logic [2:0] size_to_bytes(input wr_size_t sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_to_be(input wr_size_t sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_ep_ring.sv
// One endpoint's DEPTH-byte TX ring: storage, read/write pointers,
// occupancy and sticky overflow/underflow flags.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : flush this ring (overrides write/pop this cycle)
//   wr_req        : write request aimed at this ring
//   wr_size       : size of the write (reserved code is always rejected)
//   wr_data       : little-endian write data
//   rd_req        : pop request aimed at this ring
//   wr_ok         : write committed this cycle (combinational)
//   head_data     : byte at the read pointer, 8'h00 when empty
//   occ           : bytes currently held
//   overflow      : sticky, a write was rejected
//   underflow     : sticky, a pop hit an empty ring
module usb_tx_ep_ring
  import usb_tx_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_req,
  input  wr_size_t         wr_size,
  input  logic [31:0]      wr_data,
  input  logic             rd_req,
  output logic             wr_ok,
  output logic [7:0]       head_data,
  output logic [OCC_W-1:0] occ,
  output logic             overflow,
  output logic             underflow
);

  // NOTE: storage has no reset; occupancy alone decides which bytes are
  // valid, so flushing pointers is enough and the RAM can map to plain
  // memory without a reset network.
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [OCC_W-1:0] n_bytes;
  logic [OCC_W-1:0] free_bytes;
  logic [3:0]       wr_be;
  logic             pop_ok;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // through the if/else tree can leave one unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    n_bytes    = OCC_W'(size_to_bytes(wr_size));
    wr_be      = size_to_be(wr_size);
    free_bytes = OCC_W'(DEPTH) - occ_q;

    // Space is judged on the pre-pop occupancy; a same-cycle pop does not
    // make room for the write.
    wr_ok  = wr_req && !rst && !clear && (n_bytes != '0) && (n_bytes <= free_bytes);
    pop_ok = rd_req && !clear && (occ_q != '0);

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Pointers wrap by natural PTR_W-bit overflow (DEPTH is a power of 2).
      if (wr_ok)  wr_ptr_d = wr_ptr_q + PTR_W'(n_bytes);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d       = occ_q + (wr_ok ? n_bytes : '0) - (pop_ok ? OCC_W'(1) : '0);
      overflow_d  = overflow_q  | (wr_req && !wr_ok);
      underflow_d = underflow_q | (rd_req && (occ_q == '0));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_ptr_q + PTR_W'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  assign head_data = (occ_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign occ       = occ_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/usb_tx_multi_buffer.sv
// Multi-endpoint USB TX data buffer: NUM_EP independent DEPTH-byte rings
// between the AHB slave (1/2/4-byte writes) and the USB TX encoder (byte pops).
//   clk, rst           : clock, synchronous active-high reset
//   store_tx_data      : write strobe; wr_ep / wr_size / tx_data qualify it
//   get_tx_packet_data : pop strobe for ring rd_ep
//   tx_packet_data     : head byte of ring rd_ep (first-word fall-through)
//   clear              : per-endpoint flush mask
//   buffer_occupancy   : packed byte counts, ep k at [k*OCC_W +: OCC_W]
//   wr_accept          : write committed this cycle
//   overflow/underflow : sticky per-endpoint error flags
module usb_tx_multi_buffer
  import usb_tx_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int NUM_EP = 2,
  localparam int OCC_W  = $clog2(DEPTH + 1),
  localparam int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    store_tx_data,
  input  logic [EP_W-1:0]         wr_ep,
  input  logic [1:0]              wr_size,
  input  logic [31:0]             tx_data,
  input  logic                    get_tx_packet_data,
  input  logic [EP_W-1:0]         rd_ep,
  output logic [7:0]              tx_packet_data,
  input  logic [NUM_EP-1:0]       clear,
  output logic [NUM_EP*OCC_W-1:0] buffer_occupancy,
  output logic                    wr_accept,
  output logic [NUM_EP-1:0]       overflow,
  output logic [NUM_EP-1:0]       underflow
);

  logic [NUM_EP-1:0] ep_wr_ok;
  logic [7:0]        ep_head [NUM_EP];
  wr_size_t          wr_size_e;

  assign wr_size_e = wr_size_t'(wr_size);

  for (genvar k = 0; k < MAX_EP; k++) begin : g_ep
    if (k < NUM_EP) begin : g_ring
      usb_tx_ep_ring #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear[k]),
        .wr_req    (store_tx_data && (wr_ep == EP_W'(k))),
        .wr_size   (wr_size_e),
        .wr_data   (tx_data),
        .rd_req    (get_tx_packet_data && (rd_ep == EP_W'(k))),
        .wr_ok     (ep_wr_ok[k]),
        .head_data (ep_head[k]),
        .occ       (buffer_occupancy[k*OCC_W +: OCC_W]),
        .overflow  (overflow[k]),
        .underflow (underflow[k])
      );
    end
  end

  // Only the addressed ring can raise wr_ok, so an OR is the write mux.
  assign wr_accept = |ep_wr_ok;

  // Loop decode rather than a direct index so an rd_ep beyond NUM_EP-1
  // (possible when NUM_EP is not a power of 2) reads as 8'h00.
  always_comb begin
    tx_packet_data = 8'h00;
    for (int k = 0; k < NUM_EP; k++) begin
      if (rd_ep == EP_W'(k)) tx_packet_data = ep_head[k];
    end
  end

endmodule

// File: tb/tb_usb_tx_multi_buffer.sv
// Self-checking bench for usb_tx_multi_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_usb_tx_multi_buffer;
  import usb_tx_pkg::*;

  localparam int DEPTH  = 64;
  localparam int NUM_EP = 2;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  logic                    clk;
  logic                    rst;
  logic                    store_tx_data;
  logic [EP_W-1:0]         wr_ep;
  logic [1:0]              wr_size;
  logic [31:0]             tx_data;
  logic                    get_tx_packet_data;
  logic [EP_W-1:0]         rd_ep;
  logic [7:0]              tx_packet_data;
  logic [NUM_EP-1:0]       clear;
  logic [NUM_EP*OCC_W-1:0] buffer_occupancy;
  logic                    wr_accept;
  logic [NUM_EP-1:0]       overflow;
  logic [NUM_EP-1:0]       underflow;

  usb_tx_multi_buffer #(.DEPTH(DEPTH), .NUM_EP(NUM_EP)) dut (
    .clk                (clk),
    .rst                (rst),
    .store_tx_data      (store_tx_data),
    .wr_ep              (wr_ep),
    .wr_size            (wr_size),
    .tx_data            (tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .rd_ep              (rd_ep),
    .tx_packet_data     (tx_packet_data),
    .clear              (clear),
    .buffer_occupancy   (buffer_occupancy),
    .wr_accept          (wr_accept),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one byte queue per endpoint plus the sticky flags.
  logic [7:0]        mq [NUM_EP][$];
  logic [NUM_EP-1:0] m_ovf = '0;
  logic [NUM_EP-1:0] m_udf = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int bytes_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int occ_of(input int k);
    return int'(buffer_occupancy[k*OCC_W +: OCC_W]);
  endfunction

  // One clock cycle: drive at negedge, check all outputs against the model
  // just before the edge, then advance the model across the edge.
  task automatic step(input logic st, input int we, input logic [1:0] sz, input logic [31:0] d,
                      input logic gt, input int re, input logic [NUM_EP-1:0] clr, input logic r);
    bit exp_acc;
    int n;
    int exp_head;
    @(negedge clk);
    rst                = r;
    store_tx_data      = st;
    wr_ep              = EP_W'(we);
    wr_size            = sz;
    tx_data            = d;
    get_tx_packet_data = gt;
    rd_ep              = EP_W'(re);
    clear              = clr;
    #1;
    for (int k = 0; k < NUM_EP; k++) check($sformatf("occ%0d", k), occ_of(k), mq[k].size());
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    n        = bytes_of(sz);
    exp_acc  = st && !r && (we < NUM_EP) && !clr[we] && (n != 0) && ((DEPTH - mq[we].size()) >= n);
    exp_head = (mq[re].size() > 0) ? int'(mq[re][0]) : 0;
    check("wr_accept", wr_accept, exp_acc);
    check("tx_packet_data", tx_packet_data, exp_head);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NUM_EP; k++) mq[k].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      for (int k = 0; k < NUM_EP; k++) begin
        if (clr[k]) begin
          mq[k].delete();
          m_ovf[k] = 1'b0;
          m_udf[k] = 1'b0;
        end else begin
          if (gt && re == k) begin
            if (mq[k].size() > 0) void'(mq[k].pop_front());
            else m_udf[k] = 1'b1;
          end
          if (st && we == k) begin
            if (exp_acc) for (int i = 0; i < n; i++) mq[k].push_back(d[8*i +: 8]);
            else m_ovf[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wr(input int ep, input logic [1:0] sz, input logic [31:0] d);
    step(1'b1, ep, sz, d, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic pop(input int ep);
    step(1'b0, 0, 2'd0, 32'h0, 1'b1, ep, '0, 1'b0);
  endtask

  task automatic do_clear(input logic [NUM_EP-1:0] m);
    step(1'b0, 0, 2'd0, 32'h0, 1'b0, 0, m, 1'b0);
  endtask

  initial begin
    rst = 1'b1; store_tx_data = 1'b0; wr_ep = '0; wr_size = 2'd0; tx_data = '0;
    get_tx_packet_data = 1'b0; rd_ep = '0; clear = '0;
    repeat (2) @(posedge clk);

    // 1: reset state, WORD write and little-endian byte order on pop.
    step(1'b0, 0, 2'd0, 32'h0, 1'b0, 0, '0, 1'b1);
    wr(0, SZ_WORD, 32'hDDCC_BBAA);
    #1 check("t1_occ0_after_word", occ_of(0), 4);
    check("t1_head_aa", tx_packet_data, 8'hAA);
    repeat (4) pop(0);
    #1 check("t1_occ0_drained", occ_of(0), 0);
    check("t1_empty_data", tx_packet_data, 8'h00);

    // 2: fill ep1, then a HALF write must be rejected.
    for (int i = 0; i < DEPTH / 4; i++) wr(1, SZ_WORD, $urandom);
    #1 check("t2_occ1_full", occ_of(1), DEPTH);
    wr(1, SZ_HALF, 32'h1234);
    #1 check("t2_overflow1", overflow[1], 1'b1);
    check("t2_occ1_stays", occ_of(1), DEPTH);

    // 3: ep0 at DEPTH-1: WORD rejected, BYTE accepted, drain across the wrap.
    for (int i = 0; i < (DEPTH - 4) / 4; i++) wr(0, SZ_WORD, $urandom);
    repeat (3) wr(0, SZ_BYTE, $urandom);
    wr(0, SZ_WORD, $urandom);
    wr(0, SZ_BYTE, 32'h0000_005A);
    #1 check("t3_occ0_full", occ_of(0), DEPTH);
    repeat (DEPTH) pop(0);
    #1 check("t3_occ0_drained", occ_of(0), 0);

    // 4: same-EP write+pop and cross-EP write+pop.
    do_clear('1);
    wr(0, SZ_WORD, $urandom); wr(0, SZ_WORD, $urandom); wr(0, SZ_HALF, $urandom);
    step(1'b1, 0, SZ_WORD, $urandom, 1'b1, 0, '0, 1'b0);
    #1 check("t4_occ0_13", occ_of(0), 13);
    step(1'b1, 1, SZ_WORD, $urandom, 1'b1, 0, '0, 1'b0);
    #1 check("t4_occ1_4", occ_of(1), 4);
    check("t4_occ0_12", occ_of(0), 12);

    // 5: underflow on empty ep1, then clear overriding a write.
    do_clear(2'b10);
    pop(1);
    #1 check("t5_underflow1", underflow[1], 1'b1);
    step(1'b1, 1, SZ_BYTE, 32'h77, 1'b0, 1, 2'b10, 1'b0);
    #1 check("t5_occ1_zero", occ_of(1), 0);
    check("t5_flags1_clear", {overflow[1], underflow[1]}, 2'b00);

    // 6: reset mid-stream.
    do_clear(2'b01);
    repeat (5) wr(0, SZ_WORD, $urandom);
    #1 check("t6_occ0_20", occ_of(0), 20);
    step(1'b1, 0, SZ_WORD, $urandom, 1'b1, 0, '0, 1'b1);
    #1 check("t6_occ0_zero", occ_of(0), 0);
    check("t6_flags_zero", {overflow, underflow}, '0);

    // Randomized traffic; pop pressure alternates so rings both fill and drain.
    for (int c = 0; c < 4000; c++) begin
      logic              st, gt, r;
      logic [1:0]        sz;
      logic [NUM_EP-1:0] clr;
      int                pop_pct;
      pop_pct = ((c / 250) % 2 == 0) ? 35 : 90;
      st  = ($urandom_range(99) < 60);
      sz  = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
      gt  = ($urandom_range(99) < pop_pct);
      clr = ($urandom_range(79) == 0) ? NUM_EP'($urandom) : '0;
      r   = ($urandom_range(999) == 0);
      step(st, $urandom_range(NUM_EP - 1), sz, $urandom, gt, $urandom_range(NUM_EP - 1), clr, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
